goertzel_bank: RTL and testbench

// - Multi-bin Goertzel spectral engine for the MFCC front end. Sits between the framer and the mel filterbank.
// - Consumes one frame of FRAME_LEN signed samples. Updates NUM_BINS Goertzel recursions with one time-shared multiplier.
// - Then streams one power value per bin over a valid/ready handshake.
// - Generalises the single-width, fixed-256 engine: parametrised widths, bin count and frame length, backpressure, saturation, per-frame state clearing.

---
 rtl/goertzel_bank.sv | 222 ++++++++++++++++++++++
 tb/tb_goertzel_bank.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/goertzel_bank.sv
// goertzel_bank
// Multi-bin Goertzel spectral engine. Accepts one frame of FRAME_LEN signed
// samples, updating NUM_BINS Goertzel recursions per sample with a single
// time-shared c*q1 multiplier. Then it streams one saturated power value
// per bin over a valid/ready handshake and clears each bin's state as that
// bin's power value is transferred.
// Ports:
//   clk, rst_n    clock (rising edge) and asynchronous active-low reset
//   sample_in     framed signed sample; sample_valid/sample_ready handshake
//   coefs         bin k coefficient (signed Q3.(COEF_W-3)) at [k*COEF_W +: COEF_W]
//   pow_out       power of bin pow_bin; pow_valid/pow_ready handshake
//   pow_last      pow_out belongs to bin NUM_BINS-1
//   sat_flag      sticky per frame: a q0 or power value was clamped
module goertzel_bank #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int ACC_W     = 32,
  parameter int POW_W     = 32,
  parameter int NUM_BINS  = 8,
  parameter int FRAME_LEN = 256,
  parameter int PSHIFT    = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_W-1:0]             sample_in,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  input  logic [NUM_BINS*COEF_W-1:0]    coefs,
  output logic [POW_W-1:0]              pow_out,
  output logic [$clog2(NUM_BINS)-1:0]   pow_bin,
  output logic                          pow_valid,
  input  logic                          pow_ready,
  output logic                          pow_last,
  output logic                          sat_flag
);

  localparam int BW = $clog2(NUM_BINS);
  localparam int CW = $clog2(FRAME_LEN);
  localparam int MW = COEF_W + ACC_W;   // c*q1 product width
  localparam int SW = MW + 2;           // headroom for x + m - q2
  localparam int PW = 2 * ACC_W + 2;    // full-precision power width

  localparam logic signed [SW-1:0] ACC_MAX = {{(SW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SW-1:0] ACC_MIN = {{(SW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
  localparam logic signed [PW-1:0] POW_MAX = {{(PW-POW_W){1'b0}}, {POW_W{1'b1}}};

  typedef enum logic [1:0] {S_WAIT, S_ITER, S_POWER} state_t;

  state_t state_q, state_d;

  logic [BW-1:0]               bin_q, bin_d;
  logic [CW-1:0]               smp_cnt_q, smp_cnt_d;
  logic signed [DATA_W-1:0]    x_q, x_d;
  logic [NUM_BINS*COEF_W-1:0]  coef_q, coef_d;
  logic signed [ACC_W-1:0]     q1_q [NUM_BINS];
  logic signed [ACC_W-1:0]     q1_d [NUM_BINS];
  logic signed [ACC_W-1:0]     q2_q [NUM_BINS];
  logic signed [ACC_W-1:0]     q2_d [NUM_BINS];
  logic                        sat_q, sat_d;
  logic [POW_W-1:0]            pow_out_q, pow_out_d;
  logic [BW-1:0]               pow_bin_q, pow_bin_d;
  logic                        pow_valid_q, pow_valid_d;
  logic                        pow_last_q, pow_last_d;

  logic signed [COEF_W-1:0]    coef_sel;
  logic signed [ACC_W-1:0]     q1_sel, q2_sel, q0;
  logic signed [MW-1:0]        prod, m_full;
  logic signed [SW-1:0]        acc_sum;
  logic                        acc_hi, acc_lo;
  logic signed [PW-1:0]        q1_w, q2_w, m_w, p_full, p_sh;
  logic [POW_W-1:0]            pow_clamped;
  logic                        pow_sat;
  logic                        last_bin, last_smp, accept, xfer;

  assign last_bin = (bin_q == BW'(NUM_BINS - 1));
  assign last_smp = (smp_cnt_q == CW'(FRAME_LEN - 1));
  assign accept   = (state_q == S_WAIT) && sample_valid;
  assign xfer     = pow_valid_q && pow_ready;

  // Shared datapath: the same c*q1 product feeds the recursion in S_ITER
  // and the cross term of the power in S_POWER.
  always_comb begin
    coef_sel = coef_q[bin_q*COEF_W +: COEF_W];
    q1_sel   = q1_q[bin_q];
    q2_sel   = q2_q[bin_q];
    prod     = MW'(coef_sel) * MW'(q1_sel);
    m_full   = prod >>> (COEF_W - 3);
    acc_sum  = SW'(x_q) + SW'(m_full) - SW'(q2_sel);
    acc_hi   = acc_sum > ACC_MAX;
    acc_lo   = acc_sum < ACC_MIN;
    if (acc_hi)      q0 = ACC_MAX[ACC_W-1:0];
    else if (acc_lo) q0 = ACC_MIN[ACC_W-1:0];
    else             q0 = acc_sum[ACC_W-1:0];

    q1_w   = PW'(q1_sel);
    q2_w   = PW'(q2_sel);
    m_w    = PW'(m_full);
    p_full = q1_w * q1_w + q2_w * q2_w - m_w * q2_w;
    p_sh   = p_full >>> PSHIFT;
    if (p_sh[PW-1]) begin
      pow_clamped = '0;
      pow_sat     = 1'b1;
    end else if (p_sh > POW_MAX) begin
      pow_clamped = '1;
      pow_sat     = 1'b1;
    end else begin
      pow_clamped = p_sh[POW_W-1:0];
      pow_sat     = 1'b0;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_WAIT;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:  if (sample_valid) state_d = S_ITER;
      S_ITER:  if (last_bin) state_d = last_smp ? S_POWER : S_WAIT;
      S_POWER: if (xfer && pow_last_q) state_d = S_WAIT;
      default: state_d = S_WAIT;
    endcase
  end

  // FSM: outputs (registered outputs come straight from flops)
  always_comb begin
    sample_ready = (state_q == S_WAIT);
  end

  assign pow_out   = pow_out_q;
  assign pow_bin   = pow_bin_q;
  assign pow_valid = pow_valid_q;
  assign pow_last  = pow_last_q;
  assign sat_flag  = sat_q;

  // Datapath next-state
  always_comb begin
    bin_d       = bin_q;
    smp_cnt_d   = smp_cnt_q;
    x_d         = x_q;
    coef_d      = coef_q;
    q1_d        = q1_q;
    q2_d        = q2_q;
    sat_d       = sat_q;
    pow_out_d   = pow_out_q;
    pow_bin_d   = pow_bin_q;
    pow_valid_d = pow_valid_q;
    pow_last_d  = pow_last_q;
    case (state_q)
      S_WAIT: begin
        if (accept) begin
          x_d   = sample_in;
          bin_d = '0;
          // Coefficients are frozen for the whole frame at its first sample.
          if (smp_cnt_q == '0) begin
            coef_d = coefs;
            sat_d  = 1'b0;
          end
        end
      end
      S_ITER: begin
        q2_d[bin_q] = q1_sel;
        q1_d[bin_q] = q0;
        if (acc_hi || acc_lo) sat_d = 1'b1;
        bin_d = last_bin ? '0 : bin_q + 1'b1;
        if (last_bin) smp_cnt_d = last_smp ? '0 : smp_cnt_q + 1'b1;
      end
      S_POWER: begin
        if (!pow_valid_q) begin
          // Bubble cycle: compute and register the selected bin's power.
          pow_out_d   = pow_clamped;
          pow_bin_d   = bin_q;
          pow_last_d  = last_bin;
          pow_valid_d = 1'b1;
          if (pow_sat) sat_d = 1'b1;
        end else if (pow_ready) begin
          q1_d[pow_bin_q] = '0;
          q2_d[pow_bin_q] = '0;
          pow_valid_d     = 1'b0;
          pow_last_d      = 1'b0;
          bin_d           = last_bin ? '0 : bin_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q       <= '0;
      smp_cnt_q   <= '0;
      x_q         <= '0;
      coef_q      <= '0;
      sat_q       <= 1'b0;
      pow_out_q   <= '0;
      pow_bin_q   <= '0;
      pow_valid_q <= 1'b0;
      pow_last_q  <= 1'b0;
      for (int i = 0; i < NUM_BINS; i++) begin
        q1_q[i] <= '0;
        q2_q[i] <= '0;
      end
    end else begin
      bin_q       <= bin_d;
      smp_cnt_q   <= smp_cnt_d;
      x_q         <= x_d;
      coef_q      <= coef_d;
      sat_q       <= sat_d;
      pow_out_q   <= pow_out_d;
      pow_bin_q   <= pow_bin_d;
      pow_valid_q <= pow_valid_d;
      pow_last_q  <= pow_last_d;
      q1_q        <= q1_d;
      q2_q        <= q2_d;
    end
  end

endmodule

// File: tb/tb_goertzel_bank.sv
// tb_goertzel_bank
// Directed bench for goertzel_bank with NUM_BINS=4, FRAME_LEN=8. Three
// instances share all inputs and run in lockstep: ACC_W=32 (main), ACC_W=24
// and ACC_W=20 (shows state clamping instead of wrap).
module tb_goertzel_bank;

  logic        clk;
  logic        rst_n;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic [63:0] coefs;
  logic        pow_ready;

  logic        sample_ready_m, pow_valid_m, pow_last_m, sat_flag_m;
  logic [31:0] pow_out_m;
  logic [1:0]  pow_bin_m;
  logic        sample_ready_a, pow_valid_a, pow_last_a, sat_flag_a;
  logic [31:0] pow_out_a;
  logic [1:0]  pow_bin_a;
  logic        sample_ready_b, pow_valid_b, pow_last_b, sat_flag_b;
  logic [31:0] pow_out_b;
  logic [1:0]  pow_bin_b;

  int compared;
  int mismatched;

  logic [31:0] bm_pow  [4];
  logic [1:0]  bm_bin  [4];
  logic        bm_last [4];
  logic [31:0] ba_pow  [4];
  logic [31:0] bb_pow  [4];

  logic [31:0] exp_dc [4];

  goertzel_bank #(.DATA_W(16), .COEF_W(16), .ACC_W(32), .POW_W(32),
                  .NUM_BINS(4), .FRAME_LEN(8), .PSHIFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready_m), .coefs(coefs), .pow_out(pow_out_m),
    .pow_bin(pow_bin_m), .pow_valid(pow_valid_m), .pow_ready(pow_ready),
    .pow_last(pow_last_m), .sat_flag(sat_flag_m));

  goertzel_bank #(.DATA_W(16), .COEF_W(16), .ACC_W(24), .POW_W(32),
                  .NUM_BINS(4), .FRAME_LEN(8), .PSHIFT(0)) dut_a24 (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready_a), .coefs(coefs), .pow_out(pow_out_a),
    .pow_bin(pow_bin_a), .pow_valid(pow_valid_a), .pow_ready(pow_ready),
    .pow_last(pow_last_a), .sat_flag(sat_flag_a));

  goertzel_bank #(.DATA_W(16), .COEF_W(16), .ACC_W(20), .POW_W(32),
                  .NUM_BINS(4), .FRAME_LEN(8), .PSHIFT(0)) dut_a20 (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready_b), .coefs(coefs), .pow_out(pow_out_b),
    .pow_bin(pow_bin_b), .pow_valid(pow_valid_b), .pow_ready(pow_ready),
    .pow_last(pow_last_b), .sat_flag(sat_flag_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // bin0 = 2.0, bin1 = 1.0, bin2 = 0.0, bin3 = -1.0
  localparam logic [63:0] DC_COEFS = {16'hE000, 16'h0000, 16'h2000, 16'h4000};

  task automatic send_sample(input logic [15:0] v);
    int guard;
    guard = 0;
    while (!sample_ready_m && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!sample_ready_m) begin
      compared++; mismatched++;
      $display("FAIL sample_ready_timeout got=%0b want=1", sample_ready_m);
    end
    sample_in    = v;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] v);
    for (int i = 0; i < 8; i++) send_sample(v);
  endtask

  task automatic read_beats(input int first, input int n);
    int guard;
    pow_ready = 1'b1;
    for (int k = first; k < first + n; k++) begin
      guard = 0;
      while (!pow_valid_m && guard < 50) begin
        @(posedge clk); #1;
        guard++;
      end
      if (!pow_valid_m) begin
        compared++; mismatched++;
        $display("FAIL pow_valid_timeout beat=%0d got=%0b want=1", k, pow_valid_m);
      end
      bm_pow[k]  = pow_out_m;
      bm_bin[k]  = pow_bin_m;
      bm_last[k] = pow_last_m;
      ba_pow[k]  = pow_out_a;
      bb_pow[k]  = pow_out_b;
      $display("beat %0d: bin=%0d last=%0b pow=%0d pow24=%0d pow20=%0d",
               k, pow_bin_m, pow_last_m, pow_out_m, pow_out_a, pow_out_b);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (sample_ready_m !== 1'b1) begin mismatched++; $display("FAIL rst_sample_ready got=%0b want=1", sample_ready_m); end
    compared++;
    if (pow_valid_m !== 1'b0) begin mismatched++; $display("FAIL rst_pow_valid got=%0b want=0", pow_valid_m); end
    compared++;
    if (pow_out_m !== 32'd0) begin mismatched++; $display("FAIL rst_pow_out got=%0d want=0", pow_out_m); end
    compared++;
    if (pow_bin_m !== 2'd0 || pow_last_m !== 1'b0 || sat_flag_m !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_bin_last_sat got=%0d/%0b/%0b want=0/0/0", pow_bin_m, pow_last_m, sat_flag_m);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset: checked");
  endtask

  task automatic test_dc();
    coefs = DC_COEFS;
    send_sample(16'd100);
    coefs = 64'hDEAD_BEEF_1234_5678;   // must be ignored: frozen at first sample
    for (int i = 0; i < 7; i++) send_sample(16'd100);
    repeat (4) @(posedge clk);
    #1;
    compared++;
    if (pow_valid_m !== 1'b0 || sample_ready_m !== 1'b0) begin
      mismatched++;
      $display("FAIL dc_enter_power got=v%0b/r%0b want=v0/r0", pow_valid_m, sample_ready_m);
    end
    @(posedge clk); #1;
    compared++;
    if (pow_valid_m !== 1'b1) begin mismatched++; $display("FAIL dc_first_valid_latency got=%0b want=1", pow_valid_m); end
    read_beats(0, 4);
    for (int k = 0; k < 4; k++) begin
      compared++;
      if (bm_pow[k] !== exp_dc[k]) begin mismatched++; $display("FAIL dc_pow bin%0d got=%0d want=%0d", k, bm_pow[k], exp_dc[k]); end
      compared++;
      if (bm_bin[k] !== 2'(k)) begin mismatched++; $display("FAIL dc_pow_bin beat%0d got=%0d want=%0d", k, bm_bin[k], k); end
      compared++;
      if (bm_last[k] !== (k == 3)) begin mismatched++; $display("FAIL dc_pow_last beat%0d got=%0b want=%0b", k, bm_last[k], (k == 3)); end
    end
    compared++;
    if (sat_flag_m !== 1'b0) begin mismatched++; $display("FAIL dc_sat_flag got=%0b want=0", sat_flag_m); end
    compared++;
    if (sample_ready_m !== 1'b1) begin mismatched++; $display("FAIL dc_back_to_wait got=%0b want=1", sample_ready_m); end
    coefs = DC_COEFS;
  endtask

  task automatic test_backpressure();
    int bad;
    coefs = DC_COEFS;
    send_frame(16'd100);
    read_beats(0, 1);
    pow_ready = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      compared++;
      if (pow_valid_m !== 1'b1 || pow_out_m !== 32'd30000 || pow_bin_m !== 2'd1 || sample_ready_m !== 1'b0) begin
        mismatched++;
        $display("FAIL bp_hold cycle%0d got=v%0b/%0d/bin%0d/r%0b want=v1/30000/bin1/r0",
                 c, pow_valid_m, pow_out_m, pow_bin_m, sample_ready_m);
      end
    end
    read_beats(1, 3);
    for (int k = 0; k < 4; k++) begin
      compared++;
      if (bm_pow[k] !== exp_dc[k] || bm_bin[k] !== 2'(k)) begin
        mismatched++;
        $display("FAIL bp_beat%0d got=%0d/bin%0d want=%0d/bin%0d", k, bm_pow[k], bm_bin[k], exp_dc[k], k);
      end
    end
  endtask

  task automatic test_back_to_back();
    coefs = DC_COEFS;
    send_frame(16'd0);
    read_beats(0, 4);
    for (int k = 0; k < 4; k++) begin
      compared++;
      if (bm_pow[k] !== 32'd0) begin mismatched++; $display("FAIL b2b_zero_pow bin%0d got=%0d want=0", k, bm_pow[k]); end
    end
    compared++;
    if (sat_flag_m !== 1'b0) begin mismatched++; $display("FAIL b2b_sat_flag got=%0b want=0", sat_flag_m); end
  endtask

  task automatic test_saturation();
    coefs = {16'h0000, 16'h0000, 16'h0000, 16'h4000};
    send_frame(16'h8000);
    read_beats(0, 4);
    compared++;
    if (bm_pow[0] !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL sat_pow_acc32 got=%0h want=ffffffff", bm_pow[0]); end
    compared++;
    if (ba_pow[0] !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL sat_pow_acc24 got=%0h want=ffffffff", ba_pow[0]); end
    // ACC_W=20: q1=q2=-524288 after clamping gives exactly zero power; a wrap would not.
    compared++;
    if (bb_pow[0] !== 32'd0) begin mismatched++; $display("FAIL sat_pow_acc20_nowrap got=%0d want=0", bb_pow[0]); end
    compared++;
    if (sat_flag_m !== 1'b1 || sat_flag_a !== 1'b1 || sat_flag_b !== 1'b1) begin
      mismatched++;
      $display("FAIL sat_flags got=%0b/%0b/%0b want=1/1/1", sat_flag_m, sat_flag_a, sat_flag_b);
    end
    for (int k = 1; k < 4; k++) begin
      compared++;
      if (bm_pow[k] !== 32'd0 || bb_pow[k] !== 32'd0) begin
        mismatched++;
        $display("FAIL sat_other_bin%0d got=%0d/%0d want=0/0", k, bm_pow[k], bb_pow[k]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    coefs = DC_COEFS;
    for (int i = 0; i < 5; i++) send_sample(16'd100);
    rst_n = 1'b0;
    #2;
    compared++;
    if (sample_ready_m !== 1'b1 || pow_valid_m !== 1'b0 || pow_out_m !== 32'd0 ||
        pow_bin_m !== 2'd0 || pow_last_m !== 1'b0 || sat_flag_m !== 1'b0) begin
      mismatched++;
      $display("FAIL midrst_outputs got=r%0b/v%0b/%0d/bin%0d/l%0b/s%0b want=r1/v0/0/bin0/l0/s0",
               sample_ready_m, pow_valid_m, pow_out_m, pow_bin_m, pow_last_m, sat_flag_m);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(16'd100);
    read_beats(0, 4);
    for (int k = 0; k < 4; k++) begin
      compared++;
      if (bm_pow[k] !== exp_dc[k]) begin mismatched++; $display("FAIL midrst_dc_pow bin%0d got=%0d want=%0d", k, bm_pow[k], exp_dc[k]); end
    end
    compared++;
    if (ba_pow[0] !== 32'd640000 || bb_pow[0] !== 32'd640000) begin
      mismatched++;
      $display("FAIL midrst_narrow_pow got=%0d/%0d want=640000/640000", ba_pow[0], bb_pow[0]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    compared     = 0;
    mismatched   = 0;
    rst_n        = 1'b0;
    sample_in    = 16'd0;
    sample_valid = 1'b0;
    coefs        = '0;
    pow_ready    = 1'b1;
    // DC frame of 100: bin0 (c=2) -> (3600-2800)^2, bin1 (c=1) -> q1=200,q2=100,
    // bin2 (c=0) -> 0, bin3 (c=-1) -> q1=0,q2=100.
    exp_dc[0] = 32'd640000;
    exp_dc[1] = 32'd30000;
    exp_dc[2] = 32'd0;
    exp_dc[3] = 32'd10000;

    test_reset();
    test_dc();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_reset_mid_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
